unpack_pipe: RTL and testbench

UNPACK_PIPE -- requirements
Module: unpack_pipe

---
 rtl/unpack_pipe_if.sv | 42 ++++
 rtl/unpack_pipe.sv | 151 +++++++++++++++
 tb/tb_unpack_pipe.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/unpack_pipe_if.sv
// Operand-set handshake bundle for unpack_pipe: producer-side input channel,
// consumer-side unpacked result channel and the sticky signalling-NaN flag.
interface unpack_pipe_if #(
  parameter int FLEN = 64,
  parameter int NOPS = 3
);
  localparam int NE = (FLEN == 64) ? 11 : 8;
  localparam int NF = (FLEN == 64) ? 52 : 23;

  logic                   in_valid;
  logic                   in_ready;
  logic [NOPS*FLEN-1:0]   in_ops;
  logic [NOPS-1:0]        in_en;
  logic [1:0]             in_fmt;

  logic                   out_valid;
  logic                   out_ready;
  logic [NOPS-1:0]        out_s;
  logic [NOPS*NE-1:0]     out_e;
  logic [NOPS*(NF+1)-1:0] out_m;
  logic [NOPS-1:0]        out_nan;
  logic [NOPS-1:0]        out_snan;
  logic [NOPS-1:0]        out_zero;
  logic [NOPS-1:0]        out_inf;
  logic [NOPS-1:0]        out_subnorm;
  logic                   out_illegal;

  logic                   sticky_snan;
  logic                   sticky_clr;

  modport master (
    output in_valid, in_ops, in_en, in_fmt, out_ready, sticky_clr,
    input  in_ready, out_valid, out_s, out_e, out_m, out_nan, out_snan,
           out_zero, out_inf, out_subnorm, out_illegal, sticky_snan
  );

  modport slave (
    input  in_valid, in_ops, in_en, in_fmt, out_ready, sticky_clr,
    output in_ready, out_valid, out_s, out_e, out_m, out_nan, out_snan,
           out_zero, out_inf, out_subnorm, out_illegal, sticky_snan
  );
endinterface

// File: rtl/unpack_pipe.sv
// One-stage FP operand unpacker with valid/ready skid-free register slice.
// Half precision (fmt 10) is built only when UNPACK_PIPE_HALF_EN is defined.
module unpack_pipe #(
  parameter int FLEN = 64,
  parameter int NOPS = 3
) (
  input logic         clk,
  input logic         reset_n,
  unpack_pipe_if.slave bus
);
  localparam int NE   = (FLEN == 64) ? 11 : 8;
  localparam int NF   = (FLEN == 64) ? 52 : 23;
  localparam int BIAS = (1 << (NE - 1)) - 1;

  logic [NOPS-1:0]        n_s, n_nan, n_snan, n_zero, n_inf, n_sub;
  logic [NOPS*NE-1:0]     n_e;
  logic [NOPS*(NF+1)-1:0] n_m;
  logic                   n_ill;

  logic                   ov, sticky, ill_q;
  logic [NOPS-1:0]        s_q, nan_q, snan_q, zero_q, inf_q, sub_q;
  logic [NOPS*NE-1:0]     e_q;
  logic [NOPS*(NF+1)-1:0] m_q;
  logic                   cap, dlv;

  always_comb begin
    case (bus.in_fmt)
      2'b00:   n_ill = 1'b0;
      2'b01:   n_ill = (FLEN == 32);
`ifdef UNPACK_PIPE_HALF_EN
      2'b10:   n_ill = 1'b0;
`endif
      default: n_ill = 1'b1;
    endcase
  end

  // Each format is reduced to (sign, raw exponent, left-aligned fraction,
  // exponent-all-ones, NaN-box ok) and then classified uniformly.
  always_comb begin
    logic [63:0]   x;
    logic          sgn, emax, boxed;
    int unsigned   ein, bias_fmt;
    logic [NF-1:0] frac;
    n_s = '0; n_nan = '0; n_snan = '0; n_zero = '0; n_inf = '0; n_sub = '0;
    n_e = '0; n_m = '0;
    for (int unsigned i = 0; i < NOPS; i++) begin
      x        = 64'(bus.in_ops[i*FLEN +: FLEN]);
      sgn      = 1'b0;
      emax     = 1'b0;
      boxed    = 1'b1;
      ein      = 0;
      bias_fmt = BIAS;
      frac     = '0;
      case (bus.in_fmt)
        2'b00: begin
          boxed    = (FLEN == 32) || (&x[63:32]);
          sgn      = x[31];
          ein      = 32'(x[30:23]);
          emax     = &x[30:23];
          frac     = NF'(x[22:0]) << (NF - 23);
          bias_fmt = 127;
        end
        2'b01: begin
          sgn      = x[63];
          ein      = 32'(x[62:52]);
          emax     = &x[62:52];
          frac     = NF'(x[51:0]);
          bias_fmt = 1023;
        end
`ifdef UNPACK_PIPE_HALF_EN
        2'b10: begin
          boxed    = &x[FLEN-1:16];
          sgn      = x[15];
          ein      = 32'(x[14:10]);
          emax     = &x[14:10];
          frac     = NF'(x[9:0]) << (NF - 10);
          bias_fmt = 15;
        end
`endif
        default: ;
      endcase

      if (n_ill) begin
      end else if (!bus.in_en[i]) begin
        n_zero[i] = 1'b1;
      end else if (!boxed) begin
        n_e[i*NE +: NE]         = '1;
        n_m[i*(NF+1) +: (NF+1)] = {2'b11, {(NF-1){1'b0}}};
        n_nan[i]                = 1'b1;
      end else begin
        n_s[i] = sgn;
        if (emax) begin
          n_e[i*NE +: NE]         = '1;
          n_m[i*(NF+1) +: (NF+1)] = {1'b1, frac};
          n_inf[i]                = (frac == '0);
          n_nan[i]                = (frac != '0);
          n_snan[i]               = (frac != '0) && !frac[NF-1];
        end else if (ein == 0 && frac == '0) begin
          n_zero[i] = 1'b1;
        end else if (ein == 0) begin
          n_sub[i]                = 1'b1;
          n_e[i*NE +: NE]         = NE'(1 + BIAS - bias_fmt);
          n_m[i*(NF+1) +: (NF+1)] = {1'b0, frac};
        end else begin
          n_e[i*NE +: NE]         = NE'(ein + BIAS - bias_fmt);
          n_m[i*(NF+1) +: (NF+1)] = {1'b1, frac};
        end
      end
    end
  end

  assign bus.in_ready = !ov || bus.out_ready;
  assign cap          = bus.in_valid && bus.in_ready;
  assign dlv          = ov && bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ov     <= 1'b0;
      sticky <= 1'b0;
      ill_q  <= 1'b0;
      s_q    <= '0; nan_q <= '0; snan_q <= '0; zero_q <= '0; inf_q <= '0; sub_q <= '0;
      e_q    <= '0;
      m_q    <= '0;
    end else begin
      if (cap) begin
        ov     <= 1'b1;
        ill_q  <= n_ill;
        s_q    <= n_s;   nan_q  <= n_nan;  snan_q <= n_snan;
        zero_q <= n_zero; inf_q <= n_inf;  sub_q  <= n_sub;
        e_q    <= n_e;
        m_q    <= n_m;
      end else if (dlv) begin
        ov <= 1'b0;
      end
      if (bus.sticky_clr)          sticky <= 1'b0;
      else if (dlv && (|snan_q))   sticky <= 1'b1;
    end
  end

  assign bus.out_valid   = ov;
  assign bus.out_s       = s_q;
  assign bus.out_e       = e_q;
  assign bus.out_m       = m_q;
  assign bus.out_nan     = nan_q;
  assign bus.out_snan    = snan_q;
  assign bus.out_zero    = zero_q;
  assign bus.out_inf     = inf_q;
  assign bus.out_subnorm = sub_q;
  assign bus.out_illegal = ill_q;
  assign bus.sticky_snan = sticky;
endmodule

// File: tb/tb_unpack_pipe.sv
// Self-checking bench for unpack_pipe (FLEN=64, NOPS=3); honours UNPACK_PIPE_HALF_EN.
module tb_unpack_pipe;
  localparam int FLEN = 64;
  localparam int NOPS = 3;
  localparam int NE   = 11;
  localparam int NF   = 52;
`ifdef UNPACK_PIPE_HALF_EN
  localparam bit HALF = 1'b1;
`else
  localparam bit HALF = 1'b0;
`endif

  typedef struct packed {
    logic          s;
    logic [NE-1:0] e;
    logic [NF:0]   m;
    logic          nan, snan, zero, inf, sub;
  } op_t;

  typedef struct packed {
    logic [NOPS-1:0]        s;
    logic [NOPS*NE-1:0]     e;
    logic [NOPS*(NF+1)-1:0] m;
    logic [NOPS-1:0]        nan, snan, zero, inf, sub;
    logic                   ill;
  } set_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  unpack_pipe_if #(.FLEN(FLEN), .NOPS(NOPS)) bus ();
  unpack_pipe #(.FLEN(FLEN), .NOPS(NOPS)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int   nchk = 0;
  int   nerr = 0;
  set_t q[$];
  logic sticky_m = 1'b0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: decode fields with plain integer arithmetic from format widths.
  function automatic op_t model_op(input logic [63:0] x, input logic en, input logic [1:0] fmt);
    op_t o;
    int ew, fw, bias;
    bit boxed;
    longint unsigned expo, frac, emaxv;
    o = '0;
    if (!en) begin o.zero = 1'b1; return o; end
    case (fmt)
      2'd0:    begin ew = 8;  fw = 23; bias = 127;  boxed = (x[63:32] == 32'hFFFF_FFFF); end
      2'd1:    begin ew = 11; fw = 52; bias = 1023; boxed = 1'b1; end
      default: begin ew = 5;  fw = 10; bias = 15;   boxed = (x[63:16] == {48{1'b1}}); end
    endcase
    if (!boxed) begin
      o.e = '1; o.m = 53'h18000000000000; o.nan = 1'b1;
      return o;
    end
    frac  = x & ((64'd1 << fw) - 1);
    expo  = (x >> fw) & ((64'd1 << ew) - 1);
    emaxv = (64'd1 << ew) - 1;
    o.s   = x[ew+fw];
    if (expo == emaxv) begin
      o.e    = 11'h7FF;
      o.m    = 53'((64'd1 << 52) | (frac << (52 - fw)));
      o.inf  = (frac == 0);
      o.nan  = (frac != 0);
      o.snan = (frac != 0) && (((frac >> (fw - 1)) & 1) == 0);
    end else if (expo == 0 && frac == 0) begin
      o.zero = 1'b1;
    end else if (expo == 0) begin
      o.sub = 1'b1;
      o.e   = 11'(1 - bias + 1023);
      o.m   = 53'(frac << (52 - fw));
    end else begin
      o.e = 11'(expo - longint'(bias) + 1023);
      o.m = 53'((64'd1 << 52) | (frac << (52 - fw)));
    end
    return o;
  endfunction

  function automatic set_t model_set(input logic [NOPS*64-1:0] ops, input logic [NOPS-1:0] en,
                                     input logic [1:0] fmt);
    set_t r;
    op_t  o;
    r = '0;
    if (fmt == 2'b11 || (fmt == 2'b10 && !HALF)) begin r.ill = 1'b1; return r; end
    for (int i = 0; i < NOPS; i++) begin
      o = model_op(ops[i*64 +: 64], en[i], fmt);
      r.s[i] = o.s; r.nan[i] = o.nan; r.snan[i] = o.snan;
      r.zero[i] = o.zero; r.inf[i] = o.inf; r.sub[i] = o.sub;
      r.e[i*NE +: NE]         = o.e;
      r.m[i*(NF+1) +: (NF+1)] = o.m;
    end
    return r;
  endfunction

  function automatic set_t observe();
    return {bus.out_s, bus.out_e, bus.out_m, bus.out_nan, bus.out_snan,
            bus.out_zero, bus.out_inf, bus.out_subnorm, bus.out_illegal};
  endfunction

  function automatic logic [63:0] rnd_op();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: return r;
      1: return {32'hFFFF_FFFF, r[31:0]};
      2: return {32'hFFFF_FFFF, r[31], 8'h00, ($urandom_range(0, 1) != 0) ? r[22:0] : 23'h0};
      3: return {32'hFFFF_FFFF, r[31], 8'hFF, ($urandom_range(0, 1) != 0) ? r[22:0] : 23'h0};
      4: return {r[63], 11'h7FF, ($urandom_range(0, 1) != 0) ? r[51:0] : 52'h0};
      5: return {r[63], 11'h000, ($urandom_range(0, 1) != 0) ? r[51:0] : 52'h0};
      6: return {48'hFFFF_FFFF_FFFF, r[15:0]};
      default: return {48'hFFFF_FFFF_FFFF, r[15], 5'h1F, r[9:0]};
    endcase
  endfunction

  task automatic drive(input logic v, input logic [1:0] f, input logic [NOPS-1:0] en,
                       input logic [NOPS*64-1:0] ops, input logic rdy, input logic clr);
    bus.in_valid   = v;
    bus.in_fmt     = f;
    bus.in_en      = en;
    bus.in_ops     = ops;
    bus.out_ready  = rdy;
    bus.sticky_clr = clr;
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next one.
  task automatic tick();
    logic dlv, cap;
    #1;
    chk("out_valid", bus.out_valid, q.size() != 0);
    chk("in_ready", bus.in_ready, (q.size() == 0) || bus.out_ready);
    chk("sticky", bus.sticky_snan, sticky_m);
    if (q.size() != 0) chk("data", observe(), q[0]);
    dlv = (q.size() != 0) && bus.out_ready;
    cap = bus.in_valid && ((q.size() == 0) || bus.out_ready);
    if (bus.sticky_clr)              sticky_m = 1'b0;
    else if (dlv && (|q[0].snan))    sticky_m = 1'b1;
    if (dlv) void'(q.pop_front());
    if (cap) q.push_back(model_set(bus.in_ops, bus.in_en, bus.in_fmt));
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 2'b00, '0, '0, 1'b0, 1'b0);
    #1;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_sticky", bus.sticky_snan, 1'b0);
    chk("rst_ready", bus.in_ready, 1'b1);
    chk("rst_data", observe(), '0);

    @(negedge clk);
    reset_n = 1'b1;
    // first capture on the first edge after reset release
    drive(1, 2'b00, '1, {64'h0, 64'h0, 64'hFFFF_FFFF_3F80_0000}, 1'b1, 1'b0);
    tick();
    chk("r037_e", bus.out_e[10:0], 11'h3FF);
    chk("r037_m", bus.out_m[52:0], 53'h10000000000000);
    chk("r037_flags", {bus.out_nan[0], bus.out_snan[0], bus.out_zero[0], bus.out_inf[0],
                       bus.out_subnorm[0]}, 5'b0);

    drive(1, 2'b00, '1, {64'h0, 64'h0, 64'h0000_0000_3F80_0000}, 1'b1, 1'b0);
    tick();
    chk("r038_e", bus.out_e[10:0], 11'h7FF);
    chk("r038_m", bus.out_m[52:0], 53'h18000000000000);
    chk("r038_nan", {bus.out_nan[0], bus.out_snan[0]}, 2'b10);

    drive(1, 2'b01, '1, {64'h0, 64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000}, 1'b1, 1'b0);
    tick();
    chk("r039_snan1", bus.out_snan[1], 1'b1);
    drive(0, 2'b00, '0, '0, 1'b1, 1'b0);
    tick();
    chk("r039_sticky", bus.sticky_snan, 1'b1);
    repeat (3) tick();
    chk("r039_hold", bus.sticky_snan, 1'b1);
    bus.sticky_clr = 1'b1;
    tick();
    bus.sticky_clr = 1'b0;
    tick();
    chk("r039_clr", bus.sticky_snan, 1'b0);

    // clear wins over a simultaneous snan delivery
    drive(1, 2'b01, '1, {64'h0, 64'h7FF0_0000_0000_0001, 64'h0}, 1'b1, 1'b0);
    tick();
    drive(0, 2'b00, '0, '0, 1'b1, 1'b1);
    tick();
    bus.sticky_clr = 1'b0;
    tick();
    chk("r032_prec", bus.sticky_snan, 1'b0);

    drive(1, 2'b10, '1, {64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_3C00}, 1'b1, 1'b0);
    tick();
`ifdef UNPACK_PIPE_HALF_EN
    chk("r041_e", bus.out_e[10:0], 11'h3FF);
    chk("r041_m", bus.out_m[52:0], 53'h10000000000000);
`else
    chk("r041_ill", bus.out_illegal, 1'b1);
    chk("r041_zero", bus.out_e, '0);
`endif

    drive(1, 2'b11, '1, {64'h3FF0_0000_0000_0000, 64'h0, 64'hFFFF_FFFF_3F80_0000}, 1'b1, 1'b0);
    tick();
    chk("fmt11_ill", bus.out_illegal, 1'b1);
    chk("fmt11_flags", {bus.out_nan, bus.out_snan, bus.out_zero, bus.out_inf, bus.out_subnorm}, '0);

    drive(1, 2'b01, 3'b010, {64'hFFF0_0000_0000_0000, 64'h3FF0_0000_0000_0000,
                             64'hBFF0_0000_0000_0000}, 1'b1, 1'b0);
    tick();
    chk("dis_zero", bus.out_zero, 3'b101);
    chk("dis_sign", bus.out_s, 3'b000);

    // backpressure: hold one set in the output, keep the next one offered
    drive(1, 2'b00, '1, {64'h0, 64'hFFFF_FFFF_7F80_0000, 64'hFFFF_FFFF_C000_0000}, 1'b0, 1'b0);
    tick();
    drive(1, 2'b01, '1, {64'h4000_0000_0000_0000, 64'h0, 64'h7FF8_0000_0000_0000}, 1'b0, 1'b0);
    repeat (5) begin
      tick();
      chk("r040_stall", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();

    for (int n = 0; n < 300; n++) begin
      int unsigned f;
      f = $urandom_range(0, 9);
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      bus.in_fmt     = (f < 4) ? 2'b00 : (f < 8) ? 2'b01 : (f == 8) ? 2'b10 : 2'b11;
      bus.in_en      = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
      bus.in_ops     = {rnd_op(), rnd_op(), rnd_op()};
      bus.sticky_clr = ($urandom_range(0, 15) == 0);
      tick();
    end

    // asynchronous reset while a set is stalled and the sticky flag is set
    drive(1, 2'b01, '1, {64'h0, 64'h7FF0_0000_0000_0001, 64'h0}, 1'b1, 1'b0);
    tick();
    drive(1, 2'b01, '1, {64'h7FF4_0000_0000_0000, 64'h0, 64'h0}, 1'b1, 1'b0);
    tick();
    drive(0, 2'b00, '0, '0, 1'b0, 1'b0);
    tick();
    chk("r042_pre_valid", bus.out_valid, 1'b1);
    chk("r042_pre_sticky", bus.sticky_snan, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("r042_valid", bus.out_valid, 1'b0);
    chk("r042_sticky", bus.sticky_snan, 1'b0);
    chk("r042_data", observe(), '0);
    q.delete();
    sticky_m = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      bus.in_valid  = ($urandom_range(0, 1) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_fmt    = 2'($urandom_range(0, 1));
      bus.in_en     = 3'b111;
      bus.in_ops    = {rnd_op(), rnd_op(), rnd_op()};
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
